// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
//   Shared definitions for the multiplier arbiter slice: the arbiter FSM
//   state encoding and the requester-id width helper.
//   Optional feature macro used by the slice: MULT_ARB_SIGNED_EN.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Width of a requester index: ceil(log2(n)), never less than 1.
  function automatic int ID_W(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/multiplier_parameterized.sv
// multiplier_parameterized
//   Purely combinational unsigned multiplier keeping the full-width product.
//   Ports:
//     a       in  BIT     multiplicand
//     b       in  BIT     multiplier
//     product out 2*BIT   a*b, no truncation
module multiplier_parameterized #(
  parameter int BIT = 16
) (
  input  logic [BIT-1:0]   a,
  input  logic [BIT-1:0]   b,
  output logic [2*BIT-1:0] product
);

  assign product = {{BIT{1'b0}}, a} * {{BIT{1'b0}}, b};

endmodule

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin selector. Searches req upward from ptr,
//   wrapping from NREQ-1 to 0, and grants the first asserted bit.
//   Ports:
//     req      in  NREQ  candidate vector
//     ptr      in  IW    index with highest priority this cycle
//     grant    out NREQ  one-hot grant (all-zero when req is all-zero)
//     grant_id out IW    binary index of the granted bit (0 when none)
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = ID_W(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id
);

  int          idx;
  logic [IW-1:0] idx_w;

  // Walk the candidates from farthest to nearest so that the one closest
  // to ptr is written last and therefore wins, without needing a break.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    idx_w    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IW'(idx);
      if (req[idx_w]) begin
        grant        = '0;
        grant[idx_w] = 1'b1;
        grant_id     = idx_w;
      end
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter
//   Shares one combinational multiplier among NREQ requesters. Round-robin
//   arbitration, one operation in flight, product registered before it is
//   presented on the shared response bus.
//   Ports:
//     clk          in  1         clock, rising edge
//     rst_n        in  1         asynchronous active-low reset
//     req_valid    in  NREQ      per-requester request valid
//     req_ready    out NREQ      per-requester accept (one-hot or zero)
//     req_a        in  NREQ*BIT  multiplicands, requester i at [i*BIT +: BIT]
//     req_b        in  NREQ*BIT  multipliers, same packing
//     rsp_valid    out NREQ      per-requester response valid (one-hot or zero)
//     rsp_ready    in  NREQ      per-requester response accept
//     rsp_product  out 2*BIT     registered product
//     busy         out 1         high whenever the FSM is not IDLE
//   Optional feature: define MULT_ARB_SIGNED_EN for two's-complement
//   operands (sign/magnitude around the shared unsigned multiplier).
module multiplier_arbiter
  import mult_arb_pkg::*;
#(
  parameter int BIT  = 16,
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*BIT-1:0] req_a,
  input  logic [NREQ*BIT-1:0] req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [2*BIT-1:0]    rsp_product,
  output logic                busy
);

  localparam int            IW      = ID_W(NREQ);
  localparam int            PW      = 2 * BIT;
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [BIT-1:0]  a_q, a_d;
  logic [BIT-1:0]  b_q, b_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [PW-1:0]   mult_out;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic [BIT-1:0]  op_a, op_b;
  logic            req_hs, rsp_hs;

`ifdef MULT_ARB_SIGNED_EN
  logic sign_q, sign_d;

  // |v| for a two's-complement value; the most-negative value maps to
  // 2^(BIT-1), which still fits as an unsigned BIT-wide magnitude.
  function automatic logic [BIT-1:0] magnitude(input logic [BIT-1:0] v);
    return v[BIT-1] ? (~v + BIT'(1)) : v;
  endfunction
`endif

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  multiplier_parameterized #(
    .BIT (BIT)
  ) u_mult (
    .a       (a_q),
    .b       (b_q),
    .product (mult_out)
  );

  assign op_a   = req_a[grant_id*BIT +: BIT];
  assign op_b   = req_b[grant_id*BIT +: BIT];
  assign req_hs = (state_q == IDLE) && (|grant);
  assign rsp_hs = (state_q == RESP) && rsp_ready[id_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != IDLE);
    if (state_q == IDLE) req_ready = grant;
    if (state_q == RESP) rsp_valid = NREQ'(1) << id_q;
  end

  assign rsp_product = prod_q;

  // Datapath next values
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    prod_d = prod_q;
`ifdef MULT_ARB_SIGNED_EN
    sign_d = sign_q;
`endif
    // Operand capture at the request handshake
    if (req_hs) begin
`ifdef MULT_ARB_SIGNED_EN
      a_d    = magnitude(op_a);
      b_d    = magnitude(op_b);
      sign_d = op_a[BIT-1] ^ op_b[BIT-1];
`else
      a_d    = op_a;
      b_d    = op_b;
`endif
      id_d   = grant_id;
    end
    // Product capture: the multiplier output is registered at the end of CALC
    if (state_q == CALC) begin
`ifdef MULT_ARB_SIGNED_EN
      prod_d = sign_q ? (~mult_out + PW'(1)) : mult_out;
`else
      prod_d = mult_out;
`endif
    end
    // Priority moves past the requester just served
    if (rsp_hs) ptr_d = (id_q == LAST_ID) ? '0 : id_q + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
`ifdef MULT_ARB_SIGNED_EN
      sign_q <= 1'b0;
`endif
    end else begin
      ptr_q  <= ptr_d;
      id_q   <= id_d;
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
`ifdef MULT_ARB_SIGNED_EN
      sign_q <= sign_d;
`endif
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter
//   Scoreboard bench for multiplier_arbiter (BIT=16, NREQ=4). Honours
//   MULT_ARB_SIGNED_EN for the expected arithmetic.
module tb_multiplier_arbiter;

  localparam int BIT  = 16;
  localparam int NREQ = 4;
  localparam int PW   = 2 * BIT;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*BIT-1:0] req_a;
  logic [NREQ*BIT-1:0] req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [PW-1:0]       rsp_product;
  logic                busy;

  multiplier_arbiter #(.BIT(BIT), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [PW-1:0] prod;
  } exp_t;

  exp_t          exp_q[$];
  int            grant_log[$];
  logic [PW-1:0] rsp_log[$];
  int            mptr;
  int            hs_cyc;
  int            cyc;
  int            mon_p;
  logic [NREQ-1:0] exp_rdy, exp_rv;
  logic [PW-1:0] last_rsp;
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] ref_mul(input logic [BIT-1:0] a, input logic [BIT-1:0] b);
`ifdef MULT_ARB_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return PW'(sa * sb);
`else
    longint ua, ub;
    ua = longint'({48'd0, a});
    ub = longint'({48'd0, b});
    return PW'(ua * ub);
`endif
  endfunction

  // First asserted requester at or after p, wrapping; -1 if none.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (p + off) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor / scoreboard: sampled mid-cycle, inputs are stable here.
  initial begin
    cyc = 0; mptr = 0; hs_cyc = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      mptr = 0;
    end else begin
      exp_rdy = '0;
      exp_rv  = '0;
      mon_p   = -1;
      if (exp_q.size() == 0) begin
        mon_p = pick(req_valid, mptr);
        if (mon_p >= 0) exp_rdy[mon_p] = 1'b1;
      end else if (cyc >= hs_cyc + 2) begin
        exp_rv[exp_q[0].id] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (exp_rv != '0) begin
        chk("rsp_product", 64'(rsp_product), 64'(exp_q[0].prod));
        if (rsp_ready[exp_q[0].id]) begin
          last_rsp = rsp_product;
          rsp_log.push_back(rsp_product);
          void'(exp_q.pop_front());
        end
      end
      if (mon_p >= 0) begin
        exp_q.push_back('{id: mon_p,
                          prod: ref_mul(req_a[mon_p*BIT +: BIT], req_b[mon_p*BIT +: BIT])});
        hs_cyc = cyc;
        grant_log.push_back(mon_p);
        mptr = (mon_p + 1) % NREQ;
      end
    end
  end

  // One cycle: note accepted requests mid-cycle, retire them after the edge.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [BIT-1:0] a, input logic [BIT-1:0] b);
    req_valid[i]         = 1'b1;
    req_a[i*BIT +: BIT]  = a;
    req_b[i*BIT +: BIT]  = b;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((req_valid != '0 || exp_q.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d cycles required=<%0d", n, maxc);
      req_valid = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int base, gbase, n;
  logic [BIT-1:0] ta, tb_op;
  logic [PW-1:0]  tp;

  initial begin
    checks = 0; errors = 0; last_rsp = '0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;

    // Reset state; picker is live in IDLE even under reset
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b0110;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_product", 64'(rsp_product), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'b0010);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Simultaneous requests, two rounds
    for (int r = 0; r < 2; r++) begin
      gbase = grant_log.size();
      base  = rsp_log.size();
      for (int i = 0; i < NREQ; i++) set_req(i, BIT'(i + 1), BIT'(10));
      wait_drain(60);
      for (int i = 0; i < NREQ; i++) begin
        chk("rr_order", 64'(grant_log[gbase + i]), 64'(i));
        chk("rr_product", 64'(rsp_log[base + i]), 64'(10 * (i + 1)));
      end
    end

    // Single request on requester 2, with latency
    set_req(2, 16'd300, 16'd7);
    #1;
    chk("single_req_ready", 64'(req_ready), 64'b0100);
    step();
    step();
    @(negedge clk);
    chk("single_rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("single_product", 64'(rsp_product), 64'd2100);
    wait_drain(20);
    #1;
    chk("single_busy_after", 64'(busy), 64'd0);

    // Wrap-around: 3 served, then 0 beats 3
    set_req(3, 16'(($urandom)), 16'($urandom));
    wait_drain(20);
    gbase = grant_log.size();
    set_req(0, 16'd9, 16'd9);
    set_req(3, 16'd4, 16'd4);
    wait_drain(30);
    chk("wrap_first", 64'(grant_log[gbase]), 64'd0);
    chk("wrap_second", 64'(grant_log[gbase + 1]), 64'd3);

    // 1 and 3 requesting continuously alternate
    gbase = grant_log.size();
    n = 0;
    set_req(1, 16'($urandom), 16'($urandom));
    set_req(3, 16'($urandom), 16'($urandom));
    while (grant_log.size() < gbase + 4 && n < 60) begin
      step();
      n++;
      if (grant_log.size() < gbase + 4) begin
        if (!req_valid[1]) set_req(1, 16'($urandom), 16'($urandom));
        if (!req_valid[3]) set_req(3, 16'($urandom), 16'($urandom));
      end
    end
    req_valid = '0;
    wait_drain(30);
    for (int i = 0; i < 4; i++)
      chk("alternate", 64'(grant_log[gbase + i]), (i % 2 == 0) ? 64'd1 : 64'd3);

    // Response backpressure with a wrong-requester rsp_ready
    rsp_ready = '0;
    ta = 16'd1234; tb_op = 16'd77;
    tp = ref_mul(ta, tb_op);
    set_req(1, ta, tb_op);
    step();
    step();
    set_req(0, 16'd5, 16'd6);
    rsp_ready = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("bp_product", 64'(rsp_product), 64'(tp));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = '1;
    wait_drain(30);

    // Reset during CALC
    set_req(2, 16'd111, 16'd222);
    step();
    #1;
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_product", 64'(rsp_product), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) step();
    gbase = grant_log.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'($urandom), 16'($urandom));
    wait_drain(60);
    chk("after_reset_first", 64'(grant_log[gbase]), 64'd0);

    // Extremes
    set_req(0, 16'hFFFF, 16'hFFFF);
    wait_drain(20);
`ifdef MULT_ARB_SIGNED_EN
    chk("ext_ones", 64'(last_rsp), 64'h0000_0001);
`else
    chk("ext_ones", 64'(last_rsp), 64'hFFFE_0001);
`endif
    set_req(1, 16'hFFFD, 16'd5);
    wait_drain(20);
`ifdef MULT_ARB_SIGNED_EN
    chk("ext_neg3x5", 64'(last_rsp), 64'hFFFF_FFF1);
`else
    chk("ext_neg3x5", 64'(last_rsp), 64'h0004_FFF1);
`endif
    set_req(2, 16'h8000, 16'h8000);
    wait_drain(20);
    chk("ext_minneg", 64'(last_rsp), 64'h4000_0000);
    set_req(3, 16'h0000, 16'hFFFF);
    wait_drain(20);
    chk("ext_zero", 64'(last_rsp), 64'h0);

    // Randomised traffic with random response backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
          case ($urandom_range(0, 5))
            0:       set_req(i, 16'hFFFF, 16'($urandom));
            1:       set_req(i, 16'h8000, 16'($urandom));
            default: set_req(i, 16'($urandom), 16'($urandom));
          endcase
        end
      end
      rsp_ready = NREQ'($urandom);
      step();
    end
    rsp_ready = '1;
    wait_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
